// File: rtl/irq_prio_ctrl_pkg.sv
// Shared definitions for the interrupt priority controller: id width helper,
// source mode encoding and the grant state type.
package irq_prio_ctrl_pkg;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE  = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } grant_state_e;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/irq_prio_ctrl_if.sv
// Source/config inputs and the grant handshake between the interrupt
// controller (slave) and the CPU exception logic (master).
interface irq_prio_ctrl_if
  import irq_prio_ctrl_pkg::*;
#(
  parameter int N    = 32,
  parameter int ID_W = id_width(N)
);
  logic [N-1:0]    irq_in;
  logic [N-1:0]    edge_mode;
  logic [N-1:0]    mask;
  logic            rr_mode;
  logic            ack;
  logic            irq_valid;
  logic [N-1:0]    irq_onehot;
  logic [ID_W-1:0] irq_id;
  logic [N-1:0]    pending;

  modport slave (
    input  irq_in, edge_mode, mask, rr_mode, ack,
    output irq_valid, irq_onehot, irq_id, pending
  );

  modport master (
    output irq_in, edge_mode, mask, rr_mode, ack,
    input  irq_valid, irq_onehot, irq_id, pending
  );
endinterface

// File: rtl/irq_prio_ctrl_rr_pick.sv
// Combinational picker: rotate eligible down by the search base, take the first
// set bit with a prefix-OR, rotate the one-hot back and encode its index.
module irq_rr_pick
  import irq_prio_ctrl_pkg::*;
#(
  parameter int N    = 32,
  parameter int ID_W = id_width(N)
) (
  input  logic [N-1:0]    eligible_i,
  input  logic [ID_W-1:0] ptr_i,
  input  logic            rr_mode_i,
  output logic [N-1:0]    onehot_o,
  output logic [ID_W-1:0] id_o
);
  logic [ID_W-1:0] base;
  logic [N-1:0]    rot;
  logic [N-1:0]    seen;
  logic [N-1:0]    first;

  // Fixed priority is round-robin with the search always starting at source 0.
  assign base = rr_mode_i ? ptr_i : '0;

  always_comb begin
    int j;
    rot = '0;
    for (int i = 0; i < N; i++) begin
      j = i + int'(base);
      if (j >= N) j = j - N;
      rot[i] = eligible_i[j];
    end
  end

  assign seen[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < N; gi++) begin : g_prefix
      assign seen[gi] = seen[gi-1] | rot[gi-1];
    end
  endgenerate
  assign first = rot & ~seen;

  always_comb begin
    int j;
    onehot_o = '0;
    id_o     = '0;
    for (int i = 0; i < N; i++) begin
      j = i + int'(base);
      if (j >= N) j = j - N;
      if (first[i]) begin
        onehot_o[j] = 1'b1;
        id_o        = ID_W'(j);
      end
    end
  end
endmodule

// File: rtl/irq_sync_cell.sv
// Single-bit synchroniser chain; STAGES = 0 passes the input straight through.
module irq_sync_cell #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  generate
    if (STAGES == 0) begin : g_bypass
      assign q_o = d_i;
    end else begin : g_chain
      logic [STAGES-1:0] sync_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= d_i;
          for (int k = 1; k < STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
      end
      assign q_o = sync_q[STAGES-1];
    end
  endgenerate
endmodule

// File: rtl/irq_prio_ctrl.sv
// Interrupt pending/priority controller: synchronise, latch (edge or level),
// mask, pick by fixed or round-robin priority and hold the grant until ack.
module irq_prio_ctrl
  import irq_prio_ctrl_pkg::*;
#(
  parameter int N           = 32,
  parameter int SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            rst_n,
  irq_prio_ctrl_if.slave bus
);
  localparam int ID_W = id_width(N);

  grant_state_e    state_q, state_d;
  logic [N-1:0]    s_in, prev_s_q, rise, clr;
  logic [N-1:0]    pending_q, pending_d, eligible;
  logic [N-1:0]    onehot_q, onehot_d, pick_onehot;
  logic [ID_W-1:0] id_q, id_d, ptr_q, ptr_d, pick_id;
  logic            valid_q;

  assign valid_q = (state_q == ST_GRANT);

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_src
      irq_sync_cell #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (bus.irq_in[gi]),
        .q_o  (s_in[gi])
      );
      // A rise landing on the ack edge wins over the clear, keeping the new event.
      assign pending_d[gi] = (bus.edge_mode[gi] == MODE_EDGE)
                           ? (rise[gi] | (pending_q[gi] & ~clr[gi]))
                           : s_in[gi];
    end
  endgenerate

  assign rise     = s_in & ~prev_s_q;
  assign clr      = (valid_q && bus.ack) ? onehot_q : '0;
  assign eligible = pending_q & ~bus.mask;

  irq_rr_pick #(.N(N), .ID_W(ID_W)) u_pick (
    .eligible_i(eligible),
    .ptr_i     (ptr_q),
    .rr_mode_i (bus.rr_mode),
    .onehot_o  (pick_onehot),
    .id_o      (pick_id)
  );

  always_comb begin
    state_d  = state_q;
    onehot_d = onehot_q;
    id_d     = id_q;
    ptr_d    = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          state_d  = ST_GRANT;
          onehot_d = pick_onehot;
          id_d     = pick_id;
        end
      end
      ST_GRANT: begin
        if (bus.ack) begin
          state_d  = ST_IDLE;
          onehot_d = '0;
          id_d     = '0;
          ptr_d    = (id_q == ID_W'(N-1)) ? '0 : id_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      onehot_q  <= '0;
      id_q      <= '0;
      ptr_q     <= '0;
      pending_q <= '0;
      prev_s_q  <= '0;
    end else begin
      state_q   <= state_d;
      onehot_q  <= onehot_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      prev_s_q  <= s_in;
    end
  end

  assign bus.irq_valid  = valid_q;
  assign bus.irq_onehot = onehot_q;
  assign bus.irq_id     = id_q;
  assign bus.pending    = pending_q;
endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Directed and randomised checks of irq_prio_ctrl against a cycle-level
// reference model built from the pending/selection/handshake rules.
module tb_irq_prio_ctrl;
  localparam int N    = 8;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  irq_prio_ctrl_if #(.N(N)) bus ();

  irq_prio_ctrl #(.N(N), .SYNC_STAGES(SYNC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Reference model state
  logic [N-1:0] m_syn [SYNC];
  logic [N-1:0] m_prev, m_pend;
  bit           m_valid;
  int           m_id, m_ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < SYNC; k++) m_syn[k] = '0;
    m_prev  = '0;
    m_pend  = '0;
    m_valid = 0;
    m_id    = 0;
    m_ptr   = 0;
  endtask

  task automatic tick();
    logic [N-1:0] s, npend, elig, cur_in;
    bit nvalid;
    int nid, nptr, start, j;
    s      = m_syn[SYNC-1];
    cur_in = bus.irq_in;
    for (int i = 0; i < N; i++) begin
      if (bus.edge_mode[i]) begin
        if (s[i] && !m_prev[i])                      npend[i] = 1'b1;
        else if (bus.ack && m_valid && m_id == i)    npend[i] = 1'b0;
        else                                         npend[i] = m_pend[i];
      end else begin
        npend[i] = s[i];
      end
    end
    nvalid = m_valid; nid = m_id; nptr = m_ptr;
    if (m_valid) begin
      if (bus.ack) begin
        nvalid = 0; nid = 0; nptr = (m_id + 1) % N;
      end
    end else begin
      elig  = m_pend & ~bus.mask;
      start = bus.rr_mode ? m_ptr : 0;
      for (int k = 0; k < N; k++) begin
        j = (start + k) % N;
        if (!nvalid && elig[j]) begin
          nvalid = 1; nid = j;
        end
      end
    end
    @(posedge clk);
    for (int k = SYNC - 1; k > 0; k--) m_syn[k] = m_syn[k-1];
    m_syn[0] = cur_in;
    m_prev   = s;
    m_pend   = npend;
    m_valid  = nvalid;
    m_id     = nid;
    m_ptr    = nptr;
    #1;
    chk("model_valid",   32'(bus.irq_valid),  32'(m_valid));
    chk("model_id",      32'(bus.irq_id),     32'(m_id));
    chk("model_onehot",  32'(bus.irq_onehot), m_valid ? (32'd1 << m_id) : 32'd0);
    chk("model_pending", 32'(bus.pending),    32'(m_pend));
  endtask

  task automatic pulse(input logic [N-1:0] v);
    bus.irq_in = v;
    tick();
    bus.irq_in = '0;
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
  endtask

  task automatic wait_grant(input string tag, input int exp_id);
    int n = 0;
    while (!bus.irq_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(bus.irq_valid), 32'd1);
    chk({tag, "_id"},    32'(bus.irq_id),    32'(exp_id));
    $display("grant %s: id=%0d onehot=%02h after %0d cycles", tag, bus.irq_id, bus.irq_onehot, n);
  endtask

  // Present a grant, re-pulse sources so the rise lands exactly on the ack edge.
  task automatic repulse_ack(input logic [N-1:0] v);
    pulse(v);
    tick();
    do_ack();
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.irq_in    = '0;
    bus.edge_mode = '1;
    bus.mask      = '0;
    bus.rr_mode   = 1'b0;
    bus.ack       = 1'b0;
    model_reset();
    #12;
    chk("rst_valid",   32'(bus.irq_valid),  32'd0);
    chk("rst_onehot",  32'(bus.irq_onehot), 32'd0);
    chk("rst_id",      32'(bus.irq_id),     32'd0);
    chk("rst_pending", 32'(bus.pending),    32'd0);
    rst_n = 1'b1;
    tick();

    // Latency: pulse on source 5 presented exactly 4 clocks later
    pulse(8'h20);
    tick();
    tick();
    chk("lat_early_valid", 32'(bus.irq_valid), 32'd0);
    tick();
    chk("lat_valid",  32'(bus.irq_valid),  32'd1);
    chk("lat_id",     32'(bus.irq_id),     32'd5);
    chk("lat_onehot", 32'(bus.irq_onehot), 32'h20);
    do_ack();
    chk("lat_ack_valid",   32'(bus.irq_valid), 32'd0);
    chk("lat_ack_pending", 32'(bus.pending),   32'd0);

    // Fixed priority order 2,5,7 with a late higher-priority arrival
    pulse(8'hA4);
    wait_grant("fix2", 2);
    do_ack();
    chk("fix_idle", 32'(bus.irq_valid), 32'd0);
    tick();
    chk("fix5_valid", 32'(bus.irq_valid), 32'd1);
    chk("fix5_id",    32'(bus.irq_id),    32'd5);
    pulse(8'h02);
    tick();
    tick();
    chk("fix5_hold",    32'(bus.irq_id),  32'd5);
    chk("fix_pend_a2",  32'(bus.pending), 32'hA2);
    do_ack();
    wait_grant("fix1", 1);
    do_ack();
    wait_grant("fix7", 7);
    do_ack();

    // Round-robin alternation, then fixed repeats the lowest
    bus.rr_mode = 1'b1;
    pulse(8'h0A);
    for (int r = 0; r < 4; r++) begin
      wait_grant("rr", (r % 2 == 0) ? 1 : 3);
      repulse_ack(8'h0A);
    end
    bus.rr_mode = 1'b0;
    for (int r = 0; r < 3; r++) begin
      wait_grant("fixrep", 1);
      repulse_ack(8'h0A);
    end
    for (int r = 0; r < 12; r++) begin
      if (bus.irq_valid) do_ack();
      else tick();
    end
    chk("drain_valid",   32'(bus.irq_valid), 32'd0);
    chk("drain_pending", 32'(bus.pending),   32'd0);

    // Mask blocks selection but not pending; grant held through mask change
    bus.mask = 8'h01;
    pulse(8'h81);
    wait_grant("mask7", 7);
    bus.mask = 8'h81;
    tick();
    tick();
    chk("mask_hold_valid", 32'(bus.irq_valid), 32'd1);
    chk("mask_hold_id",    32'(bus.irq_id),    32'd7);
    do_ack();
    tick();
    tick();
    tick();
    chk("mask_none",    32'(bus.irq_valid), 32'd0);
    chk("mask_pend_01", 32'(bus.pending),   32'h01);
    bus.mask = 8'h80;
    wait_grant("mask0", 0);
    do_ack();
    bus.mask = 8'h00;

    // Level source 4 re-grants while held, drops after deassert
    bus.edge_mode = 8'hEF;
    bus.irq_in    = 8'h10;
    wait_grant("lvl4", 4);
    do_ack();
    chk("lvl_idle", 32'(bus.irq_valid), 32'd0);
    tick();
    chk("lvl_regrant_valid", 32'(bus.irq_valid), 32'd1);
    chk("lvl_regrant_id",    32'(bus.irq_id),    32'd4);
    bus.irq_in = '0;
    tick();
    tick();
    tick();
    chk("lvl_pend_drop", 32'(bus.pending),   32'd0);
    chk("lvl_held",      32'(bus.irq_valid), 32'd1);
    do_ack();
    for (int r = 0; r < 4; r++) tick();
    chk("lvl_no_grant", 32'(bus.irq_valid), 32'd0);
    bus.edge_mode = '1;

    // Rise on the ack edge of the presented source keeps it pending
    pulse(8'h08);
    wait_grant("same3", 3);
    repulse_ack(8'h08);
    chk("same_pend3", 32'(bus.pending), 32'h08);
    wait_grant("same3_again", 3);

    // Asynchronous reset while a grant is presented
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid",   32'(bus.irq_valid),  32'd0);
    chk("arst_onehot",  32'(bus.irq_onehot), 32'd0);
    chk("arst_id",      32'(bus.irq_id),     32'd0);
    chk("arst_pending", 32'(bus.pending),    32'd0);
    model_reset();
    #2 rst_n = 1'b1;
    tick();

    // Randomised traffic against the model
    for (int c = 0; c < 600; c++) begin
      if (c % 60 == 0) begin
        bus.edge_mode = N'($urandom());
        bus.mask      = N'($urandom()) & N'($urandom());
        bus.rr_mode   = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < N; i++) bus.irq_in[i] = ($urandom_range(0, 5) == 0);
      bus.ack = ($urandom_range(0, 2) == 0);
      if (c == 300) begin
        #2 rst_n = 1'b0;
        #1 model_reset();
        #2 rst_n = 1'b1;
      end
      tick();
    end
    bus.ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
